// File: rtl/uart_frame_loader_if.sv
// Byte-stream input, image-buffer write port and frame status of the UART frame loader.
// The loader uses "master"; the UART receiver / buffer / CNN start side uses "slave".
interface uart_frame_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_dv;
  logic [7:0]        rx_byte;
  logic              accept;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              frame_done;
  logic              frame_err;
  logic [1:0]        err_code;

  modport master (
    input  rx_dv, rx_byte, accept,
    output wr_en, wr_addr, wr_data, busy, frame_done, frame_err, err_code
  );

  modport slave (
    output rx_dv, rx_byte, accept,
    input  wr_en, wr_addr, wr_data, busy, frame_done, frame_err, err_code
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Hunts for a sync byte, writes N_PIXELS payload bytes to the image buffer and
// verifies a trailing 8-bit sum, reporting done or error (checksum / timeout).
module uart_frame_loader #(
  parameter int         N_PIXELS     = 784,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 50000,
  parameter int         ADDR_W       = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  uart_frame_loader_if.master bus
);

  localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PIXELS - 1);
  localparam logic [CNT_W-1:0]  CNT_TERM = CNT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHKSUM} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx, idx_next;
  logic [7:0]        sum, sum_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              wr_en_next, done_next, err_next, busy_next;
  logic [ADDR_W-1:0] wr_addr_next;
  logic [7:0]        wr_data_next;
  logic [1:0]        code_next;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    sum_next     = sum;
    cnt_next     = cnt;
    wr_en_next   = 1'b0;
    wr_addr_next = bus.wr_addr;
    wr_data_next = bus.wr_data;
    done_next    = 1'b0;
    err_next     = 1'b0;
    code_next    = bus.err_code;

    case (state)
      IDLE: begin
        if (bus.rx_dv && bus.rx_byte == SYNC_BYTE && bus.accept) begin
          state_next = PAYLOAD;
          idx_next   = '0;
          sum_next   = '0;
          cnt_next   = '0;
        end
      end
      PAYLOAD: begin
        if (bus.rx_dv) begin
          wr_en_next   = 1'b1;
          wr_addr_next = idx;
          wr_data_next = bus.rx_byte;
          sum_next     = sum + bus.rx_byte;
          cnt_next     = '0;
          if (idx == LAST_IDX) state_next = CHKSUM;
          else                 idx_next   = idx + ADDR_W'(1);
        end
      end
      CHKSUM: begin
        if (bus.rx_dv) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (bus.rx_byte == sum) begin
            done_next = 1'b1;
          end else begin
            err_next  = 1'b1;
            code_next = 2'b01;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A byte on the terminal clock wins over the timeout; the counter then holds at its terminal value.
    if (state != IDLE && !bus.rx_dv) begin
      if (cnt == CNT_TERM) begin
        state_next = IDLE;
        err_next   = 1'b1;
        code_next  = 2'b10;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end

    busy_next = (state_next != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      idx            <= '0;
      sum            <= '0;
      cnt            <= '0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.err_code   <= 2'b00;
    end else begin
      state          <= state_next;
      idx            <= idx_next;
      sum            <= sum_next;
      cnt            <= cnt_next;
      bus.wr_en      <= wr_en_next;
      bus.wr_addr    <= wr_addr_next;
      bus.wr_data    <= wr_data_next;
      bus.busy       <= busy_next;
      bus.frame_done <= done_next;
      bus.frame_err  <= err_next;
      bus.err_code   <= code_next;
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader with a 4-pixel frame and a 16-clock timeout.
module tb_uart_frame_loader;

  localparam int         N_PIX  = 4;
  localparam int         TO     = 16;
  localparam int         AW     = 2;
  localparam logic [7:0] SYNC   = 8'hA5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  typedef struct packed {
    logic       done;
    logic [1:0] code;
  } ev_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  wr_t  wr_q[$];
  ev_t  ev_q[$];
  wr_t  wr_got;
  ev_t  ev_got;

  uart_frame_loader_if #(.ADDR_W(AW)) bus();

  uart_frame_loader #(
    .N_PIXELS    (N_PIX),
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CLKS(TO),
    .ADDR_W      (AW)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; each call occupies exactly one clock.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_dv   = 1'b1;
    bus.rx_byte = b;
    @(posedge clk);
    #1;
    bus.rx_dv   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int i, input logic [7:0] d);
    wr_q.push_back('{addr: AW'(i), data: d});
  endtask

  task automatic frame(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                       input logic [7:0] p3, input logic [7:0] chk);
    logic [7:0] p[4];
    logic [7:0] s;
    p = '{p0, p1, p2, p3};
    s = 8'h00;
    send_byte(SYNC);
    for (int i = 0; i < N_PIX; i++) begin
      push_wr(i, p[i]);
      s = s + p[i];
      send_byte(p[i]);
    end
    if (chk == s) ev_q.push_back('{done: 1'b1, code: 2'b00});
    else          ev_q.push_back('{done: 1'b0, code: 2'b01});
    send_byte(chk);
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        wr_got = wr_q.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(wr_got.addr));
        check("wr_data", 32'(bus.wr_data), 32'(wr_got.data));
      end
    end
    if (bus.frame_done || bus.frame_err) begin
      check("busy_fall", 32'(bus.busy), 32'd0);
      check("ev_expected", 32'(ev_q.size() != 0), 32'd1);
      if (ev_q.size() != 0) begin
        ev_got = ev_q.pop_front();
        check("frame_done", 32'(bus.frame_done), 32'(ev_got.done));
        check("frame_err", 32'(bus.frame_err), 32'(!ev_got.done));
        if (!ev_got.done) check("err_code", 32'(bus.err_code), 32'(ev_got.code));
      end
    end
  end

  initial begin
    int lat;
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    bus.rx_dv   = 1'b0;
    bus.rx_byte = 8'h00;
    bus.accept  = 1'b1;
    #1;
    check("reset_state", 32'({bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy,
                              bus.frame_done, bus.frame_err, bus.err_code}), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Good frame followed by a bad checksum frame on the very next clock.
    frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
    frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0B);
    idle(2);
    check("busy_idle_after_err", 32'(bus.busy), 32'd0);
    check("err_code_held", 32'(bus.err_code), 32'd1);

    // Hunting with accept low: nothing may be written or started.
    bus.accept = 1'b0;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(SYNC);
    idle(1);
    check("busy_gated", 32'(bus.busy), 32'd0);
    bus.accept = 1'b1;
    frame(8'h10, 8'h20, 8'h30, 8'h40, 8'hA0);
    frame(8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00);
    frame(SYNC, SYNC, 8'h00, 8'h00, 8'h4A);

    // Timeout: error exactly TO clocks after the last byte, busy starts high.
    idle(1);
    send_byte(SYNC);
    check("busy_rise", 32'(bus.busy), 32'd1);
    bus.accept = 1'b0;
    push_wr(0, 8'h01);
    ev_q.push_back('{done: 1'b0, code: 2'b10});
    send_byte(8'h01);
    lat = 0;
    for (int k = 1; k <= TO + 4 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.frame_err) lat = k;
    end
    check("timeout_latency", 32'(lat), 32'(TO));
    bus.accept = 1'b1;
    idle(1);
    frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h1A);

    // A byte on the timeout-terminal clock is data, not a timeout.
    idle(1);
    send_byte(SYNC);
    push_wr(0, 8'h11);
    send_byte(8'h11);
    idle(TO - 1);
    push_wr(1, 8'h22);
    send_byte(8'h22);
    push_wr(2, 8'h33);
    send_byte(8'h33);
    push_wr(3, 8'h44);
    send_byte(8'h44);
    ev_q.push_back('{done: 1'b1, code: 2'b00});
    send_byte(8'hAA);
    idle(2);
    check("err_code_after_done", 32'(bus.err_code), 32'd2);

    // Asynchronous reset mid-frame: immediate return to reset values, no pulses.
    send_byte(SYNC);
    push_wr(0, 8'h01);
    send_byte(8'h01);
    push_wr(1, 8'h02);
    send_byte(8'h02);
    #5;
    check("busy_before_reset", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_midframe", 32'({bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy,
                                 bus.frame_done, bus.frame_err, bus.err_code}), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    frame(8'h09, 8'h08, 8'h07, 8'h06, 8'h1E);
    idle(4);

    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("ev_q_drained", 32'(ev_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
